// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns single-cycle load/store strobes into a
// req/ack bus transaction and stalls the core until it completes.
module dmem_bridge #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          access;
  logic          aligned;
  logic          tmo;

  assign access  = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);
  assign tmo     = !bus_ack && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (access) state_nxt = aligned ? REQ : DONE;
      REQ:  if (bus_ack || tmo) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DONE releases the core so the instruction retires exactly once
  always_comb begin
    stall = access && (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      readdata  <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
      cnt       <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= writedata;
              bus_we    <= memwrite;
              bus_req   <= 1'b1;
              cnt       <= '0;
            end else begin
              err      <= 1'b1;
              err_addr <= addr;
              if (!memwrite) readdata <= ERRDATA;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) readdata <= bus_rdata;
          end else if (tmo) begin
            bus_req  <= 1'b0;
            err      <= 1'b1;
            err_addr <= bus_addr;
            if (!bus_we) readdata <= ERRDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle datapath's memory port. It consumes aluout (address), writedata and the memread/memwrite strobes, and feeds readdata back to the result mux.
- Converts each load/store into a req/ack transaction on a variable-latency data bus.
- Holds the core via a stall output, which gates PC and register-file write enables, until the access completes, errors or times out.

Parameters:
- TIMEOUT, 16: max cycles spent in REQ without bus_ack before the access is aborted (must be >= 2).
- ERRDATA, 32'hDEADBEEF: readdata returned on an aborted or misaligned load.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high
- memread  input  1  core requests a word load this cycle
- memwrite  input  1  core requests a word store this cycle
- addr  input  32  byte address (datapath aluout)
- writedata  input  32  store data
- readdata  output  32  load result to the core
- stall  output  1  freeze the core this cycle
- err  output  1  one-cycle pulse when an access fails
- err_addr  output  32  address of the most recent failed access
- bus_req  output  1  bus request, held until ack or abort
- bus_we  output  1  1 = write, 0 = read
- bus_addr  output  32  word-aligned bus address
- bus_wdata  output  32  bus write data
- bus_rdata  input  32  bus read data, valid when bus_ack=1
- bus_ack  input  1  bus completion, single-cycle pulse

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset). The reset check happens inside the clocked process only.
- Reset values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, readdata=0, err=0, err_addr=0, timeout counter=0.
- access = memread | memwrite. If both are high, the access is a write; memread is ignored.
- stall is combinational: stall = access & (state != DONE). With no access, stall=0 in every state.
- Only bus_rdata and bus_ack are sampled from the bus. The core inputs are sampled in IDLE only and are held in registers afterwards.

FSM states:
- IDLE:
  - access and addr[1:0]==0: latch bus_addr={addr[31:2],2'b00}, bus_wdata=writedata, bus_we=memwrite; set bus_req=1; clear counter; go to REQ.
  - access and addr[1:0]!=0: no bus activity; err=1 next cycle; err_addr=addr; readdata=ERRDATA for loads; go to DONE.
  - no access: stay in IDLE.
- REQ:
  - bus_req stays 1; counter increments each cycle.
  - bus_ack=1: bus_req=0; readdata=bus_rdata if read (unchanged if write); go to DONE.
  - bus_ack=0 and counter==TIMEOUT-1: bus_req=0; err=1; err_addr=bus_addr; readdata=ERRDATA if read; go to DONE.
  - ack wins over timeout when both happen in the same cycle.
- DONE: stall=0 so the core retires the instruction at this edge; go to IDLE unconditionally. This prevents the same instruction from being re-issued.
- err is high only in the DONE cycle that follows a failure; it is 0 otherwise.

Latency and bus rules:
- Latency: 3 cycles for an aligned access acked in its first REQ cycle (IDLE, REQ, DONE); stall is high for 2 of them.
- Each extra wait cycle adds 1. Worst case is TIMEOUT+2 cycles.
- bus_ack outside REQ is ignored.
- bus_addr, bus_wdata and bus_we are stable for the whole time bus_req=1.
- Reset mid-transaction: bus_req drops at that edge and state returns to IDLE. A late bus_ack after reset is ignored.
- readdata holds its value until the next load completes. Non-memory instructions see it unchanged.

Test Plan:
1. Aligned load: addr=0x0000_0040, memread=1, bus_ack with bus_rdata=0x1234_5678 in the first REQ cycle. Required: stall=1 for 2 cycles; bus_addr=0x40, bus_we=0; readdata=0x1234_5678 in DONE; err=0.
2. Store with 3 wait cycles: memwrite=1, addr=0x100, writedata=0xCAFEF00D. Required: bus_req high for 4 cycles with bus_we=1, bus_wdata=0xCAFEF00D; stall high for 5 cycles; readdata unchanged.
3. Timeout: load at addr=0x200 and bus_ack never asserted. Required: bus_req drops after 16 cycles (TIMEOUT=16); err pulses once; err_addr=0x200; readdata=0xDEADBEEF.
4. Misaligned: memread=1, addr=0x0000_0043. Required: bus_req never asserted; stall=1 for 1 cycle; err=1 in DONE; err_addr=0x43; readdata=0xDEADBEEF.
5. Back-to-back: load then store on consecutive instructions. Required: the DONE cycle is followed by IDLE, then a fresh REQ with the new address; each instruction yields exactly one bus transaction.
6. Reset during REQ, and both strobes together:
   - Reset in cycle 2 of REQ: bus_req=0 and state=IDLE the next cycle; a subsequent stray bus_ack has no effect.
   - memread=memwrite=1: the access is issued as a write (bus_we=1).
